program_memory_ctrl: RTL and testbench

Parametrised, loadable instruction memory for the single-cycle and pipelined RISC-V cores. It replaces the read-only, combinational program ROM with a synchronous-read word array. The array has a valid/ready fetch port, range and alignment checking against a configurable text-segment base, and a streaming load port so a program can be written at run time (debug UART or testbench) without re-synthesis. It sits between the PC/fetch stage and the core's instruction register.

---
 rtl/program_memory_ctrl.sv | 117 +++++++++++
 tb/tb_program_memory_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/program_memory_ctrl.sv
// rtl/program_memory_ctrl.sv - loadable synchronous-read instruction memory
// Valid/ready fetch port with range/alignment checks, plus a streaming load port.
module program_memory_ctrl #(
  parameter int                    MEMORY_DEPTH = 256,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                Fetch_Req_i,
  input  logic [ADDR_WIDTH-1:0]               Address_i,
  output logic                                Fetch_Ready_o,
  output logic [DATA_WIDTH-1:0]               Instruction_o,
  output logic                                Instr_Valid_o,
  input  logic                                Instr_Ready_i,
  output logic [1:0]                          Instr_Err_o,
  input  logic                                Load_Start_i,
  input  logic                                Load_Valid_i,
  input  logic [DATA_WIDTH-1:0]               Load_Data_i,
  input  logic                                Load_Last_i,
  output logic                                Load_Ready_o,
  output logic                                Load_Busy_o,
  output logic [$clog2(MEMORY_DEPTH+1)-1:0]   Load_Count_o
);

  localparam int IW = $clog2(MEMORY_DEPTH);
  localparam int CW = $clog2(MEMORY_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEMORY_DEPTH);
  localparam logic [CW-1:0]         LAST_PTR = CW'(MEMORY_DEPTH - 1);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;

  logic [0:0]            state;
  logic [CW-1:0]         load_count;
  logic                  instr_valid;
  logic [1:0]            instr_err;
  logic                  rd_loaded;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rom [MEMORY_DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic [1:0]            err_code;
  logic                  accept;
  logic                  wr_en;
  logic                  load_done;

  assign off          = Address_i - BASE_ADDRESS;
  assign idx          = off >> 2;
  assign misaligned   = (Address_i[1:0] != 2'b00);
  assign out_of_range = (Address_i < BASE_ADDRESS) || (idx >= DEPTH_A);
  assign err_code     = misaligned   ? ERR_ALIGN :
                        out_of_range ? ERR_RANGE : ERR_OK;

  // Ready depends only on state and handshake signals, never on Address_i.
  assign Fetch_Ready_o = (state == ST_RUN) && !Load_Start_i &&
                         (!instr_valid || Instr_Ready_i);
  assign accept        = Fetch_Req_i && Fetch_Ready_o;
  assign Load_Ready_o  = (state == ST_LOAD);
  assign Load_Busy_o   = (state == ST_LOAD);
  assign wr_en         = (state == ST_LOAD) && Load_Valid_i;
  assign load_done     = Load_Last_i || (load_count == LAST_PTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      load_count  <= '0;
      instr_valid <= 1'b0;
      instr_err   <= ERR_OK;
      rd_loaded   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (Load_Start_i) begin
            state       <= ST_LOAD;
            load_count  <= '0;
            instr_valid <= 1'b0;
          end else if (accept) begin
            instr_valid <= 1'b1;
            instr_err   <= err_code;
            if (err_code == ERR_OK) rd_loaded <= 1'b1;
          end else if (instr_valid && Instr_Ready_i) begin
            instr_valid <= 1'b0;
          end
        end
        default: begin
          if (Load_Valid_i) begin
            load_count <= load_count + CW'(1);
            if (load_done) state <= ST_RUN;
          end
        end
      endcase
    end
  end

  // Array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) rom[load_count[IW-1:0]] <= Load_Data_i;
    if (accept && (err_code == ERR_OK)) rd_q <= rom[idx[IW-1:0]];
  end

  assign Instruction_o = (instr_err != ERR_OK) ? NOP_WORD :
                         (rd_loaded ? rd_q : '0);
  assign Instr_Valid_o = instr_valid;
  assign Instr_Err_o   = instr_err;
  assign Load_Count_o  = load_count;

endmodule

// File: tb/tb_program_memory_ctrl.sv
// tb/tb_program_memory_ctrl.sv - directed self-checking bench for program_memory_ctrl
module tb_program_memory_ctrl;

  logic        clk;
  logic        reset;
  logic        Fetch_Req_i;
  logic [31:0] Address_i;
  logic        Fetch_Ready_o;
  logic [31:0] Instruction_o;
  logic        Instr_Valid_o;
  logic        Instr_Ready_i;
  logic [1:0]  Instr_Err_o;
  logic        Load_Start_i;
  logic        Load_Valid_i;
  logic [31:0] Load_Data_i;
  logic        Load_Last_i;
  logic        Load_Ready_o;
  logic        Load_Busy_o;
  logic [8:0]  Load_Count_o;

  int n_cmp = 0;
  int n_bad = 0;

  program_memory_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .Fetch_Req_i   (Fetch_Req_i),
    .Address_i     (Address_i),
    .Fetch_Ready_o (Fetch_Ready_o),
    .Instruction_o (Instruction_o),
    .Instr_Valid_o (Instr_Valid_o),
    .Instr_Ready_i (Instr_Ready_i),
    .Instr_Err_o   (Instr_Err_o),
    .Load_Start_i  (Load_Start_i),
    .Load_Valid_i  (Load_Valid_i),
    .Load_Data_i   (Load_Data_i),
    .Load_Last_i   (Load_Last_i),
    .Load_Ready_o  (Load_Ready_o),
    .Load_Busy_o   (Load_Busy_o),
    .Load_Count_o  (Load_Count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch1(input logic [31:0] addr);
    Fetch_Req_i   = 1'b1;
    Address_i     = addr;
    Instr_Ready_i = 1'b1;
    tick();
    Fetch_Req_i   = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    Fetch_Req_i = 1'b0; Address_i = 32'h0; Instr_Ready_i = 1'b1;
    Load_Start_i = 1'b0; Load_Valid_i = 1'b0; Load_Data_i = 32'h0; Load_Last_i = 1'b0;
    repeat (3) tick();

    chk("rst_valid", Instr_Valid_o, 0);
    chk("rst_err",   Instr_Err_o, 0);
    chk("rst_instr", Instruction_o, 0);
    chk("rst_busy",  Load_Busy_o, 0);
    chk("rst_lready", Load_Ready_o, 0);
    chk("rst_count", Load_Count_o, 0);
    reset = 1'b1;
    tick();
    chk("run_fready", Fetch_Ready_o, 1);

    // Four-word load with Last on the fourth word
    Load_Start_i = 1'b1;
    #1 chk("start_forces_fready0", Fetch_Ready_o, 0);
    tick();
    Load_Start_i = 1'b0;
    chk("load_busy", Load_Busy_o, 1);
    chk("load_lready", Load_Ready_o, 1);
    chk("load_fready", Fetch_Ready_o, 0);
    for (int i = 0; i < 4; i++) begin
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'hAAAA0001 + 32'(i);
      Load_Last_i  = (i == 3);
      tick();
    end
    Load_Valid_i = 1'b0; Load_Last_i = 1'b0;
    chk("load4_count", Load_Count_o, 4);
    chk("load4_busy", Load_Busy_o, 0);

    // Back-to-back fetches
    Fetch_Req_i = 1'b1; Instr_Ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Address_i = 32'h0040_0000 + 32'(4 * i);
      tick();
      if (i == 3) Fetch_Req_i = 1'b0;
      chk("b2b_valid", Instr_Valid_o, 1);
      chk("b2b_instr", Instruction_o, 32'hAAAA0001 + 32'(i));
      chk("b2b_err", Instr_Err_o, 0);
    end
    tick();
    chk("consumed_valid", Instr_Valid_o, 0);
    chk("consumed_hold", Instruction_o, 32'hAAAA0004);

    // Backpressure hold
    Instr_Ready_i = 1'b0; Fetch_Req_i = 1'b1; Address_i = 32'h0040_0004;
    tick();
    Address_i = 32'h0040_0008;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", Instr_Valid_o, 1);
      chk("hold_instr", Instruction_o, 32'hAAAA0002);
      chk("hold_fready", Fetch_Ready_o, 0);
      tick();
    end
    chk("hold_instr_end", Instruction_o, 32'hAAAA0002);
    Fetch_Req_i = 1'b0; Instr_Ready_i = 1'b1;
    tick();
    chk("release_valid", Instr_Valid_o, 0);

    // Error decoding
    fetch1(32'h0040_0002);
    chk("misal_instr", Instruction_o, 32'h0000_0013);
    chk("misal_err", Instr_Err_o, 1);
    fetch1(32'h003F_FFFC);
    chk("below_instr", Instruction_o, 32'h0000_0013);
    chk("below_err", Instr_Err_o, 2);
    fetch1(32'h0040_0400);
    chk("idx256_err", Instr_Err_o, 2);
    chk("idx256_valid", Instr_Valid_o, 1);
    fetch1(32'h0040_0401);
    chk("precedence_err", Instr_Err_o, 1);
    fetch1(32'h0040_0008);
    chk("ok_after_err", Instruction_o, 32'hAAAA0003);
    chk("ok_after_err_code", Instr_Err_o, 0);
    tick();

    // 300-word load without Last: auto-terminates after word 256
    Load_Start_i = 1'b1;
    tick();
    Load_Start_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'hB000_0000 + 32'(i);
      tick();
      if (i == 254) chk("auto_busy_before", Load_Busy_o, 1);
      if (i == 255) begin
        chk("auto_count", Load_Count_o, 256);
        chk("auto_lready", Load_Ready_o, 0);
        chk("auto_busy", Load_Busy_o, 0);
      end
    end
    Load_Valid_i = 1'b0;
    chk("auto_count_end", Load_Count_o, 256);
    fetch1(32'h0040_03FC);
    chk("auto_last_word", Instruction_o, 32'hB000_00FF);
    fetch1(32'h0040_0000);
    chk("auto_first_word", Instruction_o, 32'hB000_0000);

    // Load_Start with a pending response and a simultaneous fetch request
    fetch1(32'h0040_0008);
    Instr_Ready_i = 1'b1; Load_Start_i = 1'b1;
    Fetch_Req_i = 1'b1; Address_i = 32'h0040_000C;
    #1 chk("start_fready", Fetch_Ready_o, 0);
    tick();
    Load_Start_i = 1'b0; Fetch_Req_i = 1'b0;
    chk("start_valid", Instr_Valid_o, 0);
    chk("start_busy", Load_Busy_o, 1);
    chk("start_count", Load_Count_o, 0);

    // Reset after two of four load words
    for (int i = 0; i < 2; i++) begin
      Load_Valid_i = 1'b1;
      Load_Data_i  = 32'hC000_0001 + 32'(i);
      tick();
    end
    Load_Valid_i = 1'b0;
    chk("mid_count", Load_Count_o, 2);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", Load_Busy_o, 0);
    chk("arst_count", Load_Count_o, 0);
    chk("arst_instr", Instruction_o, 0);
    chk("arst_lready", Load_Ready_o, 0);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_fready", Fetch_Ready_o, 1);
    fetch1(32'h0040_0004);
    chk("persist_word1", Instruction_o, 32'hC000_0002);
    fetch1(32'h0040_0008);
    chk("persist_word2", Instruction_o, 32'hB000_0002);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
